// File: rtl/nvme_cq_tracker.sv
// nvme_cq_tracker
//   Polls the NVMe completion queue one slot at a time, tells new entries
//   from stale ones with the phase bit, hands each new completion to the
//   command scheduler and rings the CQ head doorbell in batches.
//
// Ports
//   ACLK, ARESET       clock, synchronous active-high reset
//   enable             polling enable (sampled only at decision points)
//   fetch_req_*        slot read request to the CQ read engine
//   fetch_slot         slot to read, always the current head
//   cqe_*              fetched 128-bit entry from the read engine
//   cpl_*              completion to the scheduler (cid, status, error flag)
//   sq_head            SQ head pointer from the last new entry
//   db_*               CQ head doorbell write
//   dbg_state          current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid, once raised, holds itself and its payload steady until
// that edge; ready never depends on valid combinationally.

module nvme_cq_tracker #(
    parameter int QDEPTH   = 64,
    parameter int DB_BATCH = 8,
    parameter int POLL_GAP = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      enable,
    output logic                      fetch_req_valid,
    input  logic                      fetch_req_ready,
    output logic [$clog2(QDEPTH)-1:0] fetch_slot,
    input  logic                      cqe_valid,
    output logic                      cqe_ready,
    input  logic [127:0]              cqe_data,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [15:0]               cpl_cid,
    output logic [14:0]               cpl_status,
    output logic                      cpl_err,
    output logic [15:0]               sq_head,
    output logic                      db_valid,
    input  logic                      db_ready,
    output logic [$clog2(QDEPTH)-1:0] db_head,
    output logic [2:0]                dbg_state
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = $clog2(DB_BATCH + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_CHECK   = 3'd3,
        S_EMIT    = 3'd4,
        S_DB      = 3'd5,
        S_BACKOFF = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] head, head_n, head_inc;
    logic          phase, phase_n;
    logic [PW-1:0] pending, pending_n, pend_inc;
    logic [GW-1:0] gap_cnt;
    logic          from_stale, from_stale_n;
    logic [31:0]   dw3_q;
    logic [15:0]   dw2_q;
    logic          is_new;
    logic          unused_cqe;

    // Only DW2[15:0] and DW3 carry information this block needs.
    assign unused_cqe = ^{cqe_data[95:80], cqe_data[63:0]};

    assign head_inc  = head + 1'b1;
    assign pend_inc  = pending + 1'b1;
    assign is_new    = (dw3_q[16] == phase);
    assign dbg_state = state;

    always_comb begin
        state_n      = state;
        head_n       = head;
        phase_n      = phase;
        pending_n    = pending;
        from_stale_n = from_stale;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_REQ;
                end else if (pending != '0) begin
                    state_n      = S_DB;
                    from_stale_n = 1'b0;
                end
            end
            S_REQ:   if (fetch_req_ready) state_n = S_WAIT;
            S_WAIT:  if (cqe_valid) state_n = S_CHECK;
            S_CHECK: begin
                if (is_new) begin
                    state_n = S_EMIT;
                end else if (pending != '0) begin
                    // Flush what we owe before backing off on an empty queue.
                    state_n      = S_DB;
                    from_stale_n = 1'b1;
                end else begin
                    state_n = S_BACKOFF;
                end
            end
            S_EMIT: begin
                if (cpl_ready) begin
                    head_n       = head_inc;
                    pending_n    = pend_inc;
                    from_stale_n = 1'b0;
                    if (head == AW'(QDEPTH - 1)) phase_n = ~phase;
                    // pending is at least 1 after consuming, so a disabled
                    // tracker always flushes before going idle.
                    if (pend_inc == PW'(DB_BATCH)) state_n = S_DB;
                    else if (!enable)              state_n = S_DB;
                    else                           state_n = S_REQ;
                end
            end
            S_DB: begin
                if (db_ready) begin
                    pending_n = '0;
                    if (from_stale)  state_n = S_BACKOFF;
                    else if (enable) state_n = S_REQ;
                    else             state_n = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (gap_cnt == '0) state_n = enable ? S_REQ : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state           <= S_IDLE;
            head            <= '0;
            phase           <= 1'b1;
            pending         <= '0;
            gap_cnt         <= '0;
            from_stale      <= 1'b0;
            dw3_q           <= '0;
            dw2_q           <= '0;
            fetch_req_valid <= 1'b0;
            cqe_ready       <= 1'b0;
            cpl_valid       <= 1'b0;
            db_valid        <= 1'b0;
            fetch_slot      <= '0;
            db_head         <= '0;
            cpl_cid         <= '0;
            cpl_status      <= '0;
            cpl_err         <= 1'b0;
            sq_head         <= '0;
        end else begin
            state      <= state_n;
            head       <= head_n;
            phase      <= phase_n;
            pending    <= pending_n;
            from_stale <= from_stale_n;

            // Outputs are decoded from the next state so they line up with
            // the state register on the same edge.
            fetch_req_valid <= (state_n == S_REQ);
            cqe_ready       <= (state_n == S_WAIT);
            cpl_valid       <= (state_n == S_EMIT);
            db_valid        <= (state_n == S_DB);
            fetch_slot      <= head_n;

            if (state_n == S_BACKOFF && state != S_BACKOFF)
                gap_cnt <= GW'(POLL_GAP - 1);
            else if (state == S_BACKOFF && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;

            // Doorbell value is frozen when DB is entered.
            if (state_n == S_DB && state != S_DB)
                db_head <= head_n;

            if (state == S_WAIT && cqe_valid) begin
                dw3_q <= cqe_data[127:96];
                dw2_q <= cqe_data[79:64];
            end

            if (state == S_CHECK && is_new) begin
                cpl_cid    <= dw3_q[15:0];
                cpl_status <= dw3_q[31:17];
                cpl_err    <= (dw3_q[31:17] != 15'd0);
                sq_head    <= dw2_q;
            end
        end
    end

endmodule
